// File: rtl/led_sequencer.sv
// Parametrised LED pattern sequencer: four pattern modes, programmable step
// period and pass count, with start/stop/done handshake and sticky time_end.
module led_sequencer #(
    parameter int unsigned LED_W  = 24,
    parameter int unsigned DIV_W  = 28,
    parameter int unsigned LOOP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  div,
    input  logic [LOOP_W-1:0] loops,
    output logic [LED_W-1:0]  led,
    output logic              busy,
    output logic              done,
    output logic              time_end
);

    localparam int unsigned IDX_W = $clog2(2 * LED_W);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               time_end_q, time_end_d;
    logic [DIV_W-1:0]   step_q, step_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LOOP_W-1:0]  pass_q, pass_d;
    logic [1:0]         mode_q, mode_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [LOOP_W-1:0]  loops_q, loops_d;

    logic               tick;
    logic               last_pat;
    logic               final_pass;
    logic [LOOP_W:0]    pass_inc;

    // Pattern for step index i of a pass in mode m.
    function automatic logic [LED_W-1:0] pattern(input logic [1:0] m,
                                                 input logic [IDX_W-1:0] i);
        logic [LED_W-1:0] one;
        one = LED_W'(1);
        case (m)
            2'd0:    pattern = one << i;
            2'd1:    pattern = one << (IDX_W'(LED_W - 1) - i);
            2'd2:    pattern = (i < IDX_W'(LED_W)) ? (one << i)
                                                   : (one << (IDX_W'(2 * LED_W - 2) - i));
            default: pattern = {LED_W{1'b1}} >> (IDX_W'(LED_W - 1) - i);
        endcase
    endfunction

    // div_q already holds max(div,1), so the timer wraps at div_q-1.
    assign tick       = (step_q == (div_q - DIV_W'(1)));
    assign last_pat   = (mode_q == 2'd2) ? (idx_q == IDX_W'(2 * LED_W - 3))
                                         : (idx_q == IDX_W'(LED_W - 1));
    assign pass_inc   = {1'b0, pass_q} + (LOOP_W + 1)'(1);
    assign final_pass = (loops_q != '0) && (pass_inc >= {1'b0, loops_q});

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            led_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            time_end_q <= 1'b0;
            step_q     <= '0;
            idx_q      <= '0;
            pass_q     <= '0;
            mode_q     <= '0;
            div_q      <= '0;
            loops_q    <= '0;
        end else begin
            state_q    <= state_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            time_end_q <= time_end_d;
            step_q     <= step_d;
            idx_q      <= idx_d;
            pass_q     <= pass_d;
            mode_q     <= mode_d;
            div_q      <= div_d;
            loops_q    <= loops_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        time_end_d = time_end_q;
        step_d     = step_q;
        idx_d      = idx_q;
        pass_d     = pass_q;
        mode_d     = mode_q;
        div_d      = div_q;
        loops_d    = loops_q;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d    = RUN;
                    busy_d     = 1'b1;
                    time_end_d = 1'b0;
                    led_d      = pattern(mode, '0);
                    step_d     = '0;
                    idx_d      = '0;
                    pass_d     = '0;
                    mode_d     = mode;
                    div_d      = (div == '0) ? DIV_W'(1) : div;
                    loops_d    = loops;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    led_d   = '0;
                    busy_d  = 1'b0;
                    step_d  = '0;
                    idx_d   = '0;
                    pass_d  = '0;
                end else if (tick) begin
                    step_d = '0;
                    if (!last_pat) begin
                        idx_d = idx_q + IDX_W'(1);
                        led_d = pattern(mode_q, idx_q + IDX_W'(1));
                    end else if (!final_pass) begin
                        idx_d = '0;
                        led_d = pattern(mode_q, '0);
                        if (pass_q != '1) begin
                            pass_d = pass_q + LOOP_W'(1);
                        end
                    end else begin
                        state_d    = IDLE;
                        led_d      = '0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        time_end_d = 1'b1;
                        idx_d      = '0;
                        pass_d     = '0;
                    end
                end else begin
                    step_d = step_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign led      = led_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign time_end = time_end_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer (LED_W=8): the driver queues expected
// per-cycle outputs, the monitor pops one whenever busy or done is high.
module tb_led_sequencer;

    localparam int unsigned LED_W  = 8;
    localparam int unsigned DIV_W  = 28;
    localparam int unsigned LOOP_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic [1:0]        mode;
    logic [DIV_W-1:0]  div;
    logic [LOOP_W-1:0] loops;
    logic [LED_W-1:0]  led;
    logic              busy;
    logic              done;
    logic              time_end;

    typedef struct packed {
        logic [7:0] led;
        logic       done;
        logic       te;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Hand-computed pattern tables for LED_W=8.
    logic [7:0] seq_sl [8]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] seq_sr [8]  = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] seq_bn [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
    logic [7:0] seq_fl [8]  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

    led_sequencer #(.LED_W(LED_W), .DIV_W(DIV_W), .LOOP_W(LOOP_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .div      (div),
        .loops    (loops),
        .led      (led),
        .busy     (busy),
        .done     (done),
        .time_end (time_end)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int m, input int i);
        case (m)
            0:       pat = seq_sl[i];
            1:       pat = seq_sr[i];
            2:       pat = seq_bn[i];
            default: pat = seq_fl[i];
        endcase
    endfunction

    function automatic int plen(input int m);
        plen = (m == 2) ? 14 : 8;
    endfunction

    // Expected trace of a complete run, ending with the done cycle.
    function automatic void push_run(input int m, input int d, input int l);
        int de;
        de = (d == 0) ? 1 : d;
        for (int p = 0; p < l; p++)
            for (int i = 0; i < plen(m); i++)
                for (int c = 0; c < de; c++)
                    q.push_back('{led: pat(m, i), done: 1'b0, te: 1'b0});
        q.push_back('{led: 8'h00, done: 1'b1, te: 1'b1});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic issue(input logic [1:0] m, input int d, input int l, input logic s);
        @(posedge clk); #1;
        start = 1'b1;
        stop  = s;
        mode  = m;
        div   = DIV_W'(d);
        loops = LOOP_W'(l);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: %0d entries left after %0d cycles", name, q.size(), budget);
            q.delete();
        end
    endtask

    // Monitor: every busy or done cycle must match the next queued entry.
    always @(negedge clk) begin
        if (rst && (busy || done)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected output: led=0x%0h busy=%0b done=%0b te=%0b at %0t",
                         led, busy, done, time_end, $time);
            end else begin
                mon_e = q.pop_front();
                if (led !== mon_e.led || done !== mon_e.done || busy !== !mon_e.done ||
                    time_end !== mon_e.te) begin
                    errors++;
                    $display("FAIL scoreboard: got led=0x%0h busy=%0b done=%0b te=%0b expected led=0x%0h busy=%0b done=%0b te=%0b at %0t",
                             led, busy, done, time_end, mon_e.led, !mon_e.done, mon_e.done,
                             mon_e.te, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        mode  = 2'd0;
        div   = '0;
        loops = '0;
        #12;
        check("reset led", 32'(led), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset time_end", 32'(time_end), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // mode0, div=3, loops=1: done exactly at edge 25
        push_run(0, 3, 1);
        issue(2'd0, 3, 1, 1'b0);
        idle_cycle();
        repeat (23) @(posedge clk);
        @(posedge clk); #1;
        check("mode0 done at edge 25", 32'(done), 32'h1);
        check("mode0 led cleared at done", 32'(led), 32'h0);
        drain("mode0", 50);
        @(posedge clk); #1;
        check("time_end sticky", 32'(time_end), 32'h1);
        check("done single pulse", 32'(done), 32'h0);

        // mode2, div=0 (acts as 1), loops=2: done at edge 29
        push_run(2, 0, 2);
        issue(2'd2, 0, 2, 1'b0);
        idle_cycle();
        repeat (27) @(posedge clk);
        @(posedge clk); #1;
        check("bounce done at edge 29", 32'(done), 32'h1);
        drain("bounce", 50);

        // mode3 then mode1 back to back, second start right after done
        push_run(3, 2, 1);
        push_run(1, 2, 1);
        issue(2'd3, 2, 1, 1'b0);
        idle_cycle();
        repeat (15) @(posedge clk);
        issue(2'd1, 2, 1, 1'b0);
        check("fill done at edge 17", 32'(done), 32'h1);
        idle_cycle();
        drain("fill+shift-right", 60);

        // start re-asserted while busy is ignored
        push_run(0, 1, 1);
        issue(2'd0, 1, 1, 1'b0);
        idle_cycle();
        issue(2'd3, 5, 3, 1'b0);
        idle_cycle();
        drain("restart ignored", 40);

        // loops=0 runs until stop at edge 50
        for (int k = 0; k < 50; k++)
            q.push_back('{led: seq_sl[k % 8], done: 1'b0, te: 1'b0});
        issue(2'd0, 1, 0, 1'b0);
        idle_cycle();
        repeat (48) @(posedge clk);
        @(posedge clk); #1;
        stop = 1'b1;
        check("free-run busy before stop", 32'(busy), 32'h1);
        @(posedge clk); #1;
        stop = 1'b0;
        check("stop led", 32'(led), 32'h0);
        check("stop busy", 32'(busy), 32'h0);
        check("stop time_end", 32'(time_end), 32'h0);
        check("stop no done", 32'(done), 32'h0);
        drain("free-run", 5);

        // start and stop together in IDLE: nothing starts
        issue(2'd0, 1, 1, 1'b1);
        idle_cycle();
        repeat (3) @(posedge clk);
        #1;
        check("start+stop idle busy", 32'(busy), 32'h0);
        check("start+stop idle led", 32'(led), 32'h0);

        // asynchronous reset mid-run, then a clean run
        push_run(0, 1, 1);
        issue(2'd0, 1, 1, 1'b0);
        idle_cycle();
        repeat (8) @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("async reset led", 32'(led), 32'h0);
        check("async reset busy", 32'(busy), 32'h0);
        check("async reset done", 32'(done), 32'h0);
        check("async reset time_end", 32'(time_end), 32'h0);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        push_run(1, 1, 1);
        issue(2'd1, 1, 1, 1'b0);
        idle_cycle();
        drain("after reset", 40);
        @(posedge clk); #1;
        check("after reset time_end", 32'(time_end), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
